// File: rtl/axi4_stream_arb_pkg.sv
// rtl/axi4_stream_arb_pkg.sv - shared types and helpers for the packet arbiter
package axi4_stream_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of a grant index; a single requester still needs one bit.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - AXI4-Stream bundle with master/slave views
// master drives tvalid/tdata/tstrb/tkeep/tlast/tuser/tdest/tid, slave drives tready.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid, input tready);
  modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid, output tready);
endinterface

// File: rtl/rr_arbiter_pick.sv
// rtl/rr_arbiter_pick.sv - combinational round-robin pick
// req_i: request vector; last_grant_i: previous winner.
// found_o: any request present; idx_o: first requester after last_grant_i, wrapping.
module rr_arbiter_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_grant_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int             start;

  // Rotating the doubled vector puts last_grant+1 at bit 0, so a plain
  // lowest-bit priority encode yields the round-robin winner.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    start   = (int'(last_grant_i) + 1) % N;
    req_dbl = {req_i, req_i};
    req_rot = req_dbl[start +: N];
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found_o = 1'b1;
        idx_o   = W'((start + i) % N);
      end
    end
  end

endmodule

// File: rtl/axi4_stream_pkt_arbiter.sv
// rtl/axi4_stream_pkt_arbiter.sv - packet-granularity round-robin AXI4-Stream arbiter
// clk_i/rst_i: clock, async active-high reset. pkt_i[]: requester streams.
// pkt_o: arbitrated stream. grant_o: current/last granted input. busy_o: packet in flight.
module axi4_stream_pkt_arbiter
  import axi4_stream_arb_pkg::*;
#(
  parameter int INPUTS_NUM  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int USER_WIDTH  = 1,
  parameter int DEST_WIDTH  = 1,
  parameter int ID_WIDTH    = 1,
  parameter int GRANT_WIDTH = grant_width(INPUTS_NUM)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  axi4_stream_if.slave           pkt_i [INPUTS_NUM],
  axi4_stream_if.master          pkt_o,
  output logic [GRANT_WIDTH-1:0] grant_o,
  output logic                   busy_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  arb_state_e             state, state_nxt;
  logic [GRANT_WIDTH-1:0] grant, grant_nxt;
  logic [GRANT_WIDTH-1:0] last_grant, last_grant_nxt;

  logic [INPUTS_NUM-1:0]  req_vld, req_last, in_ready;
  logic [DATA_WIDTH-1:0]  req_data [INPUTS_NUM];
  logic [STRB_WIDTH-1:0]  req_strb [INPUTS_NUM];
  logic [STRB_WIDTH-1:0]  req_keep [INPUTS_NUM];
  logic [USER_WIDTH-1:0]  req_user [INPUTS_NUM];
  logic [DEST_WIDTH-1:0]  req_dest [INPUTS_NUM];
  logic [ID_WIDTH-1:0]    req_id   [INPUTS_NUM];

  logic                   pick_found;
  logic [GRANT_WIDTH-1:0] pick_idx;
  logic                   busy, out_valid, out_last;

  // Interface arrays only allow constant indices, so flatten to plain arrays.
  for (genvar g = 0; g < INPUTS_NUM; g++) begin : g_in
    assign req_vld[g]      = pkt_i[g].tvalid;
    assign req_last[g]     = pkt_i[g].tlast;
    assign req_data[g]     = pkt_i[g].tdata;
    assign req_strb[g]     = pkt_i[g].tstrb;
    assign req_keep[g]     = pkt_i[g].tkeep;
    assign req_user[g]     = pkt_i[g].tuser;
    assign req_dest[g]     = pkt_i[g].tdest;
    assign req_id[g]       = pkt_i[g].tid;
    assign pkt_i[g].tready = in_ready[g];
  end

  rr_arbiter_pick #(
    .N (INPUTS_NUM),
    .W (GRANT_WIDTH)
  ) u_pick (
    .req_i        (req_vld),
    .last_grant_i (last_grant),
    .found_o      (pick_found),
    .idx_o        (pick_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GRANT_WIDTH'(INPUTS_NUM - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (out_valid && pkt_o.tready && out_last) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data path is a pure mux; only tvalid/tready are gated by the lock.
  assign busy      = (state == LOCKED);
  assign out_valid = busy && req_vld[grant];
  assign out_last  = req_last[grant];

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < INPUTS_NUM; i++) begin
      in_ready[i] = busy && (grant == GRANT_WIDTH'(i)) && pkt_o.tready;
    end
  end

  assign pkt_o.tvalid = out_valid;
  assign pkt_o.tlast  = out_last;
  assign pkt_o.tdata  = req_data[grant];
  assign pkt_o.tstrb  = req_strb[grant];
  assign pkt_o.tkeep  = req_keep[grant];
  assign pkt_o.tuser  = req_user[grant];
  assign pkt_o.tdest  = req_dest[grant];
  assign pkt_o.tid    = req_id[grant];

  assign grant_o = grant;
  assign busy_o  = busy;

endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// tb/tb_axi4_stream_pkt_arbiter.sv - directed self-checking bench for the packet arbiter
module tb_axi4_stream_pkt_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  grant;
  logic        busy;
  logic        o_tready;

  logic [3:0]  src_valid, src_last, src_ready;
  logic [31:0] src_data [4];

  int len [4], cnt [4], seq [4], pkts_left [4];
  bit stall [4];
  bit hs [4];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(32)) src_if [4] ();
  axi4_stream_if #(.DATA_WIDTH(32)) sink_if ();

  for (genvar g = 0; g < 4; g++) begin : g_src
    assign src_if[g].tvalid = src_valid[g];
    assign src_if[g].tdata  = src_data[g];
    assign src_if[g].tstrb  = 4'hF;
    assign src_if[g].tkeep  = 4'hF;
    assign src_if[g].tlast  = src_last[g];
    assign src_if[g].tuser  = 1'(g);
    assign src_if[g].tdest  = 1'(g >> 1);
    assign src_if[g].tid    = 1'(g);
    assign src_ready[g]     = src_if[g].tready;
  end
  assign sink_if.tready = o_tready;

  axi4_stream_pkt_arbiter #(
    .INPUTS_NUM (4),
    .DATA_WIDTH (32),
    .USER_WIDTH (1),
    .DEST_WIDTH (1),
    .ID_WIDTH   (1)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .pkt_i   (src_if),
    .pkt_o   (sink_if),
    .grant_o (grant),
    .busy_o  (busy)
  );

  function automatic logic [31:0] word(input int k, input int s, input int w);
    return {8'(k), 8'(s), 16'(w)};
  endfunction

  task automatic drive_srcs();
    for (int k = 0; k < 4; k++) begin
      src_valid[k] = (pkts_left[k] > 0) && !stall[k];
      src_data[k]  = word(k, seq[k], cnt[k]);
      src_last[k]  = (cnt[k] == len[k] - 1);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      len[k] = 1; cnt[k] = 0; seq[k] = 0; pkts_left[k] = 0; stall[k] = 0;
    end
    drive_srcs();
  endtask

  // Handshakes are captured in the settled region before the edge, then the
  // source model advances 1 time unit after it.
  task automatic cycle();
    for (int k = 0; k < 4; k++) hs[k] = src_valid[k] && src_ready[k];
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (hs[k]) begin
        if (src_last[k]) begin
          cnt[k] = 0; seq[k]++; pkts_left[k]--;
        end else begin
          cnt[k]++;
        end
      end
    end
    drive_srcs(); #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    o_tready = 1'b1;
    clear_model();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    reset_dut();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (grant !== 2'd0) begin miscompares++; $display("FAIL reset_grant: got %0d want 0", grant); end
    vectors++; if (sink_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", sink_if.tvalid); end
    vectors++; if (src_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b want 0000", src_ready); end
  endtask

  task automatic test_single();
    reset_dut();
    len[2] = 3; pkts_left[2] = 1; drive_srcs(); #1;
    vectors++; if (src_ready[2] !== 1'b0 || sink_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL single_idle: ready %b tvalid %b want 0 0", src_ready[2], sink_if.tvalid); end
    cycle();
    for (int w = 0; w < 3; w++) begin
      vectors++; if (grant !== 2'd2 || busy !== 1'b1) begin miscompares++; $display("FAIL single_grant w%0d: grant %0d busy %b want 2 1", w, grant, busy); end
      vectors++; if (sink_if.tvalid !== 1'b1 || sink_if.tdata !== word(2, 0, w)) begin miscompares++; $display("FAIL single_data w%0d: got %b/%h want 1/%h", w, sink_if.tvalid, sink_if.tdata, word(2, 0, w)); end
      vectors++; if (sink_if.tlast !== (w == 2)) begin miscompares++; $display("FAIL single_last w%0d: got %b", w, sink_if.tlast); end
      cycle();
    end
    vectors++; if (sink_if.tdest !== 1'b1 || sink_if.tid !== 1'b0) begin miscompares++; $display("FAIL single_sideband: dest %b id %b want 1 0", sink_if.tdest, sink_if.tid); end
    vectors++; if (busy !== 1'b0 || grant !== 2'd2) begin miscompares++; $display("FAIL single_done: busy %b grant %0d want 0 2", busy, grant); end
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int k = 0; k < 4; k++) begin len[k] = 2; pkts_left[k] = 2; end
    drive_srcs(); #1;
    for (int p = 0; p < 5; p++) begin
      vectors++; if (busy !== 1'b0 || sink_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL rr_gap p%0d: busy %b tvalid %b want 0 0", p, busy, sink_if.tvalid); end
      cycle();
      vectors++; if (grant !== 2'(p % 4)) begin miscompares++; $display("FAIL rr_grant p%0d: got %0d want %0d", p, grant, p % 4); end
      for (int w = 0; w < 2; w++) begin
        vectors++; if (sink_if.tdata !== word(p % 4, p / 4, w) || src_ready !== 4'(1 << (p % 4))) begin miscompares++; $display("FAIL rr_word p%0d w%0d: data %h ready %b want %h %b", p, w, sink_if.tdata, src_ready, word(p % 4, p / 4, w), 4'(1 << (p % 4))); end
        cycle();
      end
    end
  endtask

  task automatic test_lock_contention();
    reset_dut();
    len[1] = 3; pkts_left[1] = 1; drive_srcs(); #1;
    cycle(); cycle();
    len[0] = 2; pkts_left[0] = 1; drive_srcs(); #1;
    for (int w = 1; w < 3; w++) begin
      vectors++; if (src_ready[0] !== 1'b0 || grant !== 2'd1 || sink_if.tdata !== word(1, 0, w)) begin miscompares++; $display("FAIL lock_hold w%0d: ready0 %b grant %0d data %h want 0 1 %h", w, src_ready[0], grant, sink_if.tdata, word(1, 0, w)); end
      cycle();
    end
    vectors++; if (busy !== 1'b0 || src_ready[0] !== 1'b0) begin miscompares++; $display("FAIL lock_gap: busy %b ready0 %b want 0 0", busy, src_ready[0]); end
    cycle();
    vectors++; if (grant !== 2'd0 || sink_if.tdata !== word(0, 0, 0) || src_ready[0] !== 1'b1) begin miscompares++; $display("FAIL lock_next: grant %0d data %h ready0 %b want 0 %h 1", grant, sink_if.tdata, src_ready[0], word(0, 0, 0)); end
    cycle(); cycle();
  endtask

  task automatic test_backpressure();
    logic       rdy_pat [6];
    int         exp_w   [6];
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_w   = '{0, 1, 1, 1, 2, 3};
    reset_dut();
    len[3] = 4; pkts_left[3] = 1; drive_srcs(); #1;
    cycle();
    for (int c = 0; c < 6; c++) begin
      o_tready = rdy_pat[c]; #1;
      vectors++; if (sink_if.tvalid !== 1'b1 || sink_if.tdata !== word(3, 0, exp_w[c]) || src_ready[3] !== rdy_pat[c]) begin miscompares++; $display("FAIL bp c%0d: data %h ready %b want %h %b", c, sink_if.tdata, src_ready[3], word(3, 0, exp_w[c]), rdy_pat[c]); end
      cycle();
    end
    vectors++; if (busy !== 1'b0 || pkts_left[3] !== 0) begin miscompares++; $display("FAIL bp_done: busy %b left %0d want 0 0", busy, pkts_left[3]); end
  endtask

  task automatic test_source_stall();
    reset_dut();
    len[1] = 4; pkts_left[1] = 1; drive_srcs(); #1;
    cycle(); cycle(); cycle();
    stall[1] = 1; len[0] = 1; pkts_left[0] = 1; len[2] = 1; pkts_left[2] = 1; drive_srcs(); #1;
    for (int c = 0; c < 3; c++) begin
      vectors++; if (busy !== 1'b1 || grant !== 2'd1 || sink_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL stall c%0d: busy %b grant %0d tvalid %b want 1 1 0", c, busy, grant, sink_if.tvalid); end
      cycle();
    end
    stall[1] = 0; drive_srcs(); #1;
    vectors++; if (sink_if.tvalid !== 1'b1 || sink_if.tdata !== word(1, 0, 2)) begin miscompares++; $display("FAIL stall_resume: tvalid %b data %h want 1 %h", sink_if.tvalid, sink_if.tdata, word(1, 0, 2)); end
    cycle(); cycle(); cycle();
    vectors++; if (grant !== 2'd2) begin miscompares++; $display("FAIL stall_next: grant %0d want 2", grant); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    len[2] = 5; pkts_left[2] = 1; drive_srcs(); #1;
    cycle(); cycle(); cycle();
    vectors++; if (sink_if.tdata !== word(2, 0, 2)) begin miscompares++; $display("FAIL rstmid_pre: data %h want %h", sink_if.tdata, word(2, 0, 2)); end
    rst = 1'b1; #1;
    vectors++; if (sink_if.tvalid !== 1'b0 || busy !== 1'b0 || grant !== 2'd0) begin miscompares++; $display("FAIL rstmid_async: tvalid %b busy %b grant %0d want 0 0 0", sink_if.tvalid, busy, grant); end
    reset_dut();
    for (int k = 0; k < 4; k++) begin len[k] = 1; pkts_left[k] = 1; end
    drive_srcs(); #1;
    cycle();
    vectors++; if (grant !== 2'd0 || sink_if.tdata !== word(0, 0, 0)) begin miscompares++; $display("FAIL rstmid_first: grant %0d data %h want 0 %h", grant, sink_if.tdata, word(0, 0, 0)); end
  endtask

  initial begin
    o_tready = 1'b1;
    clear_model();
    test_reset();
    test_single();
    test_round_robin();
    test_lock_contention();
    test_backpressure();
    test_source_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4_stream_pkt_arbiter.md
# axi4_stream_pkt_arbiter

Packet-granularity round-robin arbiter that shares one AXI4-Stream output among `INPUTS_NUM` requesters, typically the packet-mode single-clock FIFOs that buffer each source. A grant is taken on the first word of a packet and held until the `tlast` handshake, so packets are never interleaved. It sits between the per-source packet FIFOs and a shared downstream consumer such as a MAC, DMA or further FIFO.

## Interface
- `INPUTS_NUM`, 4: number of requesters, ≥1.
- `DATA_WIDTH`, 32: `tdata` width; `tstrb`/`tkeep` width is `DATA_WIDTH/8`.
- `USER_WIDTH`, 1: `tuser` width.
- `DEST_WIDTH`, 1: `tdest` width.
- `ID_WIDTH`, 1: `tid` width.
- `GRANT_WIDTH`, derived: `INPUTS_NUM > 1 ? $clog2(INPUTS_NUM) : 1`.

- `clk_i`  input  1  clock.
- `rst_i`  input  1  reset, asynchronous, active-high.
- `pkt_i[INPUTS_NUM]`  `axi4_stream_if.slave`  array  requester streams.
- `pkt_o`  `axi4_stream_if.master`  1  arbitrated output stream.
- `grant_o`  output  `GRANT_WIDTH`  index of the current or last granted input.
- `busy_o`  output  1  high while a packet is being forwarded (LOCKED).

## Operation
- Two-state FSM: IDLE and LOCKED.
- **IDLE**
  - `pkt_o.tvalid=0`; all `pkt_i[k].tready=0`.
  - The round-robin pick scans inputs starting at `last_grant+1` and wrapping modulo `INPUTS_NUM`. It selects the first `k` with `pkt_i[k].tvalid=1`.
  - If a candidate exists, register `grant <= k` and go to LOCKED.
- **LOCKED**
  - `pkt_o.{tvalid,tdata,tstrb,tkeep,tlast,tuser,tdest,tid}` are driven combinationally from `pkt_i[grant]`.
  - `pkt_i[grant].tready = pkt_o.tready`; every other input has `tready=0`.
  - On `pkt_o.tvalid && pkt_o.tready && pkt_o.tlast`: `last_grant <= grant` and go to IDLE.
- The grant is frozen for the whole of LOCKED.
  - Source dropping `tvalid` mid-packet: output `tvalid` drops, lock is held with no timeout.
  - Non-granted sources asserting `tvalid`: they wait.
- `grant_o` mirrors the `grant` register. `busy_o = (state == LOCKED)`.
- No payload is modified, buffered or dropped. Word order and count within each packet are preserved.

## Timing
- Reset values: state=IDLE, `grant=0`, `last_grant=INPUTS_NUM-1`, so input 0 wins the first arbitration. `pkt_o.tvalid=0`, all `tready=0`, `grant_o=0`, `busy_o=0`.
- Arbitration latency: 1 cycle.
  - `tvalid` seen in the IDLE cycle → LOCKED on the next edge.
  - The first word can transfer in the first LOCKED cycle.
- Within a packet, throughput is 1 word/cycle and there are no arbiter-inserted bubbles.
- Inter-packet gap is exactly 1 IDLE cycle after the `tlast` handshake, even if requests are pending. Peak efficiency is therefore `L/(L+1)` for `L`-word packets.
- Single-word packet (`tlast` on the first word): LOCKED lasts 1 cycle when `tready=1`.
- Backpressure: while `pkt_o.tready=0` in LOCKED, the output is whatever the granted source holds stable. The AXI stability rule is inherited from the source; the arbiter adds no registers in the data path.
- Fairness: with all inputs continuously requesting, grants cycle 0,1,…,N-1,0. No input waits more than `INPUTS_NUM-1` packets.
- `INPUTS_NUM=1`: `grant` is always 0. The block reduces to a pass-through plus 1 IDLE cycle between packets.
- `rst_i` mid-packet: immediate return to IDLE with reset values. The partially forwarded packet is truncated and the source must be reset as well.

## Structure
- Shared package `axi4_stream_arb_pkg`: FSM state enum (IDLE, LOCKED) and a `grant_width(n)` helper function used to derive `GRANT_WIDTH`.
- One sub-module, `rr_arbiter_pick`: combinational round-robin pick.
  - Inputs: request vector and `last_grant`.
  - Outputs: `found` and `idx`.
  - Implementation: double-width rotate and priority encode.
- The FSM, `grant`/`last_grant` registers and output mux live in the top level.

## Test plan
- **Single requester**: input 2 sends a 3-word packet with `pkt_o.tready=1`. Expect `grant_o=2`, output words identical in the 3 cycles after the IDLE cycle, then `busy_o=0`.
- **Round robin**: all 4 inputs hold 2-word packets continuously. Expect grant order 0,1,2,3,0 with a 1-cycle gap between packets, and no interleaved words.
- **Lock under contention**: input 1 is mid-packet when input 0 raises `tvalid`. Expect `pkt_i[0].tready=0` until input 1's `tlast` handshake; input 0 is granted after the next IDLE cycle.
- **Backpressure**: toggle `pkt_o.tready` 1,0,0,1 during a 4-word packet. Expect the output held stable while stalled, and a source word consumed only when `tready=1`.
- **Source stall**: the granted input drops `tvalid` for 3 cycles mid-packet while others request. Expect `busy_o=1` throughout, grant unchanged, `pkt_o.tvalid=0` during the gap.
- **Async reset mid-packet**: assert `rst_i` on word 2 of 5. Expect on the same cycle `pkt_o.tvalid=0`, `busy_o=0`, `grant_o=0`; after release with all inputs requesting, input 0 is granted first.
